// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache between fetch and the memory controller.
// A flush mid-miss drains the outstanding response so the controller handshake completes cleanly.
module icache_direct #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        if_ask,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        mem_ask,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_inst,
  input  logic        rob_clear
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;

  typedef enum logic [1:0] {S_IDLE, S_MISS, S_DRAIN} state_t;

  state_t             state_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES];
  logic               if_valid_q;
  logic [31:0]        if_inst_q;
  logic               mem_ask_q;
  logic [31:0]        mem_addr_q;

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]      req_tag, fill_tag;
  logic                  hit, fill_en;
  logic [3:0]            unused_bits;

  assign req_idx  = if_addr[INDEX_BITS+1:2];
  assign req_tag  = if_addr[31:INDEX_BITS+2];
  // Fill always targets the latched request, since if_addr may move after a flush.
  assign fill_idx = mem_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mem_addr_q[31:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign fill_en  = rdy_in && mem_valid && (state_q != S_IDLE);
  assign unused_bits = {if_addr[1:0], mem_addr_q[1:0]};

  assign if_valid = if_valid_q;
  assign if_inst  = if_inst_q;
  assign mem_ask  = mem_ask_q;
  assign mem_addr = mem_addr_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      if_valid_q <= 1'b0;
      if_inst_q  <= '0;
      mem_ask_q  <= 1'b0;
      mem_addr_q <= '0;
    end else if (rdy_in) begin
      if_valid_q <= 1'b0;
      if (fill_en) valid_q[fill_idx] <= 1'b1;
      case (state_q)
        S_IDLE: begin
          // if_valid_q high means fetch has not yet moved to its next PC: bubble.
          if (if_ask && !if_valid_q && !rob_clear) begin
            if (hit) begin
              if_valid_q <= 1'b1;
              if_inst_q  <= data_q[req_idx];
            end else begin
              mem_ask_q  <= 1'b1;
              mem_addr_q <= {if_addr[31:2], 2'b00};
              state_q    <= S_MISS;
            end
          end
        end
        S_MISS: begin
          if (mem_valid) begin
            if (!rob_clear) begin
              if_valid_q <= 1'b1;
              if_inst_q  <= mem_inst;
            end
            mem_ask_q <= 1'b0;
            state_q   <= S_IDLE;
          end else if (rob_clear) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_valid) begin
            mem_ask_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_inst;
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// Randomized bench for icache_direct: acts as fetch unit and memory controller,
// checking against a word-address-keyed model of the cache contents.
module tb_icache_direct;
  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, if_ask, mem_valid, rob_clear;
  logic [31:0] if_addr, mem_inst;
  logic        if_valid, mem_ask;
  logic [31:0] if_inst, mem_addr;

  int n_chk = 0;
  int n_err = 0;

  // Model: per line, whether it holds a word, which word address, and its data.
  bit          mv  [16];
  logic [29:0] mwa [16];
  logic [31:0] mdat[16];

  icache_direct #(.INDEX_BITS(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .if_ask(if_ask), .if_addr(if_addr), .if_valid(if_valid), .if_inst(if_inst),
    .mem_ask(mem_ask), .mem_addr(mem_addr), .mem_valid(mem_valid),
    .mem_inst(mem_inst), .rob_clear(rob_clear)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  // mode 0: plain, 1: flush while waiting (drain), 2: flush coincident with mem_valid.
  // dly < 0 picks a random memory latency.
  task automatic fetch(input logic [31:0] a, input int mode, input logic [31:0] md, input int dly);
    int idx;
    bit hit;
    int d;
    logic [31:0] wa;
    idx = int'(a[5:2]);
    hit = mv[idx] && (mwa[idx] == a[31:2]);
    wa  = {a[31:2], 2'b00};
    if_ask = 1'b1; if_addr = a;
    step();
    if (hit) begin
      chk("hit_vld", if_valid, 1);
      chk("hit_inst", if_inst, mdat[idx]);
      chk("hit_mask", mem_ask, 0);
      if_ask = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        rdy_in = 1'b0;
        step();
        chk("frz_vld", if_valid, 1);
        rdy_in = 1'b1;
      end
      step();
      chk("hit_end", if_valid, 0);
    end else begin
      chk("miss_mask", mem_ask, 1);
      chk("miss_addr", mem_addr, wa);
      chk("miss_vld", if_valid, 0);
      d = (dly >= 0) ? dly : int'($urandom_range(0, 3));
      if (mode == 1 && d < 1) d = 1;
      for (int i = 0; i < d; i++) begin
        rob_clear = (mode == 1) && (i == 0 || $urandom_range(0, 1) == 1);
        rdy_in    = !((mode == 0) && ($urandom_range(0, 4) == 0));
        step();
        rob_clear = 1'b0; rdy_in = 1'b1;
        if (mode == 1) begin
          if_ask = 1'b0; if_addr = $urandom;
        end
        chk("wait_mask", mem_ask, 1);
        chk("wait_addr", mem_addr, wa);
        chk("wait_vld", if_valid, 0);
      end
      mem_valid = 1'b1; mem_inst = md; rob_clear = (mode == 2);
      step();
      mem_valid = 1'b0; rob_clear = 1'b0; if_ask = 1'b0;
      chk("rsp_vld", if_valid, (mode == 0) ? 1 : 0);
      if (mode == 0) chk("rsp_inst", if_inst, md);
      chk("rsp_mask", mem_ask, 0);
      mv[idx] = 1'b1; mwa[idx] = a[31:2]; mdat[idx] = md;
      step();
      chk("rsp_end", if_valid, 0);
    end
  endtask

  initial begin
    logic [31:0] a;
    rst_n_in = 1'b0; rdy_in = 1'b1; if_ask = 1'b0; if_addr = '0;
    mem_valid = 1'b0; mem_inst = '0; rob_clear = 1'b0;
    model_clear();
    #12;
    chk("rst_vld", if_valid, 0);
    chk("rst_inst", if_inst, 0);
    chk("rst_mask", mem_ask, 0);
    chk("rst_maddr", mem_addr, 0);
    rst_n_in = 1'b1;
    step();

    // Cold miss then hit.
    fetch(32'h10, 0, 32'h13, 2);
    fetch(32'h10, 0, 32'h0, -1);
    // Conflict eviction on index 4.
    fetch(32'h54, 0, 32'h1111_1111, 1);
    fetch(32'h10, 0, 32'h0, -1);
    fetch(32'h50, 0, 32'h2222_2222, 1);
    fetch(32'h10, 0, 32'h3333_3333, 0);
    // Flush during miss, then drained data hits.
    fetch(32'h20, 1, 32'hCAFE_0020, 3);
    fetch(32'h20, 0, 32'h0, -1);
    // Flush coincident with mem_valid.
    fetch(32'h24, 2, 32'hBEEF_0024, 1);
    fetch(32'h24, 0, 32'h0, -1);

    // Bubble and hold: if_ask held high on a hit address.
    if_ask = 1'b1; if_addr = 32'h10;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bub_vld", if_valid, (i % 2 == 0) ? 1 : 0);
      chk("bub_mask", mem_ask, 0);
    end
    if_ask = 1'b0;
    step();

    // Flush in IDLE blocks acceptance that cycle.
    if_ask = 1'b1; if_addr = 32'h3C; rob_clear = 1'b1;
    step();
    chk("iflush_mask", mem_ask, 0);
    chk("iflush_vld", if_valid, 0);
    rob_clear = 1'b0; if_ask = 1'b0;
    step();

    // Async reset mid-miss.
    if_ask = 1'b1; if_addr = 32'h30;
    step();
    chk("pre_rst_mask", mem_ask, 1);
    #2 rst_n_in = 1'b0;
    #1;
    chk("arst_mask", mem_ask, 0);
    chk("arst_vld", if_valid, 0);
    chk("arst_maddr", mem_addr, 0);
    #1 rst_n_in = 1'b1; if_ask = 1'b0;
    model_clear();
    step();
    fetch(32'h10, 0, 32'h4444_4444, 1);

    // Randomized traffic over a small address pool to force hits and conflicts.
    for (int n = 0; n < 300; n++) begin
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      fetch(a, ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0, $urandom, -1);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
